// File: rtl/mul16_pkg.sv
// Shared constants and FSM state encoding for the sequential multiplier.
package mul16_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_CNT_W = 5;

    // 2'd3 is unused and decodes back to IDLE in the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul16_add16_c.sv
// WIDTH-bit ripple-carry adder (full-adder chain, carry-in tied low) with carry-out.
module add16_c
    import mul16_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/mul16_seq.sv
// Unsigned shift-and-add multiplier, one multiplier bit per clock, valid/ready on both sides.
// Optional build macro MUL16_ZERO_BYPASS_EN: zero operands skip the BUSY iterations.
module mul16_seq
    import mul16_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic               zero_op;

`ifdef MUL16_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign addend  = acc_lo[0] ? mcand : '0;
    assign product = {acc_hi, acc_lo};

    add16_c #(.WIDTH(WIDTH)) u_add (
        .a    (acc_hi),
        .b    (addend),
        .sum  (sum),
        .cout (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = zero_op ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Carry-out becomes the new MSB of acc_hi as the accumulator shifts right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        if (zero_op) begin
                            acc_lo <= '0;
                            cnt    <= '0;
                        end else begin
                            acc_lo <= b;
                            cnt    <= CNT_W'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= {carry, sum[WIDTH-1:1]};
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed self-checking bench for mul16_seq; expectations follow MUL16_ZERO_BYPASS_EN when defined.
module tb_mul16_seq;
    import mul16_pkg::*;

`ifdef MUL16_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int tests;
    int failures;

    mul16_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && dut.state == BUSY) begin
            assert (dut.cnt != '0) else $error("cnt reached 0 in BUSY");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] op_a, input logic [15:0] op_b);
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_done(output int edges, output logic saw_busy);
        edges    = 0;
        saw_busy = busy;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) saw_busy = 1'b1;
        end
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_iready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          edges;
        logic        saw_busy;
        logic [31:0] held;
        int          handshakes;
        logic [31:0] hs_product;

        tests     = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3 * 5
        start_op(16'd3, 16'd5);
        wait_done(edges, saw_busy);
        check("t35_latency", 32'(edges), 32'd16);
        check("t35_product", product, 32'h0000_000F);
        check("t35_busy_seen", 32'(saw_busy), 32'd1);
        finish_op("t35");

        // carry-out every step
        start_op(16'hFFFF, 16'hFFFF);
        wait_done(edges, saw_busy);
        check("tff_latency", 32'(edges), 32'd16);
        check("tff_product", product, 32'hFFFE_0001);
        finish_op("tff");

        // backpressure hold
        out_ready = 1'b0;
        start_op(16'h8000, 16'h0002);
        wait_done(edges, saw_busy);
        check("thold_product", product, 32'h0001_0000);
        held = product;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("thold_valid", 32'(out_valid), 32'd1);
            check("thold_stable", product, held);
            check("thold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        finish_op("thold");

        // asynchronous reset mid-BUSY
        start_op(16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("tabort_out_valid", 32'(out_valid), 32'd0);
        check("tabort_busy", 32'(busy), 32'd0);
        check("tabort_product", product, 32'd0);
        check("tabort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_op(16'd7, 16'd9);
        wait_done(edges, saw_busy);
        check("t79_latency", 32'(edges), 32'd16);
        check("t79_product", product, 32'h0000_003F);
        finish_op("t79");

        // new operands during BUSY are ignored: 0x0ABC * 0x0013 = 0xCBF4
        start_op(16'h0ABC, 16'h0013);
        in_valid   = 1'b1;
        a          = 16'd1;
        b          = 16'd1;
        handshakes = 0;
        hs_product = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) in_valid = 1'b0;
            if (out_valid && out_ready) begin
                handshakes++;
                hs_product = product;
            end
        end
        check("tign_handshakes", 32'(handshakes), 32'd1);
        check("tign_product", hs_product, 32'h0000_CBF4);

        // zero operand
        start_op(16'h0000, 16'h1234);
        wait_done(edges, saw_busy);
        check("tzero_latency", 32'(edges), BYPASS ? 32'd0 : 32'd16);
        check("tzero_product", product, 32'd0);
        check("tzero_busy_seen", 32'(saw_busy), BYPASS ? 32'd0 : 32'd1);
        finish_op("tzero");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Multi-cycle unsigned shift-and-add multiplier that consumes the 16-bit adder datapath.
- Accepts two WIDTH-bit operands over a valid/ready handshake and iterates one multiplier bit per clock.
- Presents the full 2*WIDTH-bit product over a valid/ready handshake.
- Sits downstream of the 16-bit ripple adder and feeds the ALU/register stage.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand; index 0 = LSB.
- b  input  WIDTH  multiplier; index 0 = LSB.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b unsigned; index 0 = LSB.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; all registers clear.
  - in_ready=1 once reset deasserts; out_valid=0, product=0, busy=0.
- Registers:
  - mcand: WIDTH bits.
  - acc_hi: WIDTH bits.
  - acc_lo: WIDTH bits; holds the multiplier and fills with low product bits.
  - cnt: CNT_W bits.
- States: IDLE, BUSY, DONE. Encoding lives in the package.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: mcand<=a, acc_lo<=b, acc_hi<=0, cnt<=WIDTH, go BUSY.
- BUSY, one step per edge:
  - {c,s} = acc_hi + (acc_lo[0] ? mcand : 0), a WIDTH-bit add with carry-out c.
  - {acc_hi,acc_lo} <= {c,s,acc_lo} >> 1, i.e. acc_hi<={c,s[WIDTH-1:1]}, acc_lo<={s[0],acc_lo[WIDTH-1:1]}.
  - cnt<=cnt-1.
  - If cnt==1 at the edge, go DONE.
- DONE:
  - out_valid=1; product={acc_hi,acc_lo}.
  - On an edge with out_ready=1, go IDLE.
- Latency: operands accepted at edge E0; out_valid rises after edge E0+WIDTH (16 cycles by default).
- Throughput: one operation per WIDTH+2 cycles minimum. in_ready=0 in BUSY and DONE; there is no overlap of output and input handshakes.
- in_valid, a and b are ignored outside IDLE; changing them during BUSY has no effect.
- product is driven from registers and holds stable while out_valid=1 and out_ready=0, for any number of cycles.
- product is don't-care outside DONE, but must equal the register contents (no X).
- Carry-out c must be kept; dropping it is a bug, e.g. 0xFFFF*0xFFFF.
- Reset mid-BUSY or mid-DONE: operation is aborted, no output is produced, and the block returns to the IDLE reset values.
- cnt never wraps; reaching 0 in BUSY is illegal, and an assertion in the bench flags it.

Optional Feature:
- Macro: MUL16_ZERO_BYPASS_EN.
- Defined: in IDLE, on accept with a==0 or b==0, the block goes straight to DONE with acc_hi=acc_lo=0. Latency is then 1 cycle and busy never asserts for that operation.
- Undefined: every operation takes the full WIDTH BUSY cycles regardless of operand values.
- Product values are identical in both builds.

Decomposition:
- Package mul16_pkg:
  - Constants MUL_WIDTH=16 and MUL_CNT_W=5.
  - State typedef/encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
- Sub-module add16_c:
  - Combinational WIDTH-bit adder returning sum and carry-out.
  - Built from the existing FullAdder chain with carry-in tied 0.
  - Instantiated once for the BUSY step.

Test Plan:
- a=3, b=5, in_valid for 1 cycle, out_ready=1 → out_valid after 16 cycles, product=0x0000000F, in_ready returns 1 the next cycle.
- a=0xFFFF, b=0xFFFF → product=0xFFFE0001 (exercises carry-out every step).
- a=0x8000, b=0x0002 → product=0x00010000. Hold out_ready=0 for 5 cycles: out_valid and product stay constant, in_ready=0 throughout.
- Start a=0x1234, b=0x5678; pulse rst_n low at BUSY cycle 7 → all outputs 0 immediately. Then a new op a=7, b=9 yields product=0x0000003F.
- In BUSY, drive in_valid=1 with a=1, b=1 → ignored; the original op's product is correct and only one out_valid handshake occurs.
- With MUL16_ZERO_BYPASS_EN: a=0, b=0x1234 → out_valid 1 cycle after accept, product=0, busy stays 0. Without the macro: same product after 16 cycles.
